// File: rtl/nibble_serial_pkg.sv
// Shared definitions for the nibble-serial adder controller.
// Optional feature macro used by the controller: NIBBLE_SERIAL_SUB_MODE_EN.
package nibble_serial_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/nibble_rca4.sv
// 4-bit ripple-carry adder slice built from four full adders.
module nibble_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_rca4
   import nibble_serial_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);
   logic [NIBBLE_W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      nibble_fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign cout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer computing a WIDTH-bit add through one 4-bit RCA slice, LS nibble first.
// Optional subtract mode: define NIBBLE_SERIAL_SUB_MODE_EN to add the 'sub' port.
module nibble_serial_add_ctrl
   import nibble_serial_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_MODE_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
   localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             amsb_q, amsb_d;
   logic             bmsb_q, bmsb_d;

   logic [WIDTH-1:0]    b_in;
   logic                c_in;
   logic [NIBBLE_W-1:0] slice_s;
   logic                slice_co;
   logic [WIDTH-1:0]    slice_top;
   logic                accept;
   logic                last;

   nibble_rca4 u_rca (
      .a    (a_q[NIBBLE_W-1:0]),
      .b    (b_q[NIBBLE_W-1:0]),
      .cin  (c_q),
      .s    (slice_s),
      .cout (slice_co)
   );

   assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
   assign last      = (state_q == RUN) && (idx_q == LAST_IDX);
   // Slice result placed in the top nibble; shift form also covers WIDTH=4.
   assign slice_top = WIDTH'(slice_s) << (WIDTH - NIBBLE_W);

   // Operand conditioning: subtract stores ~b and forces the initial carry.
   always_comb begin
      b_in = b;
      c_in = cin;
`ifdef NIBBLE_SERIAL_SUB_MODE_EN
      if (sub) begin
         b_in = ~b;
         c_in = 1'b1;
      end
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: capture on accept, shift one nibble per RUN cycle.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      c_d    = c_q;
      sum_d  = sum_q;
      idx_d  = idx_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      amsb_d = amsb_q;
      bmsb_d = bmsb_q;
      if (accept) begin
         a_d    = a;
         b_d    = b_in;
         c_d    = c_in;
         sum_d  = '0;
         idx_d  = '0;
         amsb_d = a[WIDTH-1];
         bmsb_d = b_in[WIDTH-1];
      end else if (state_q == RUN) begin
         a_d   = a_q >> NIBBLE_W;
         b_d   = b_q >> NIBBLE_W;
         c_d   = slice_co;
         sum_d = (sum_q >> NIBBLE_W) | slice_top;
         idx_d = idx_q + IDX_W'(1);
         if (last) begin
            cout_d = slice_co;
            ovf_d  = (amsb_q == bmsb_q) && (slice_s[NIBBLE_W-1] != amsb_q);
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= 1'b0;
         sum_q  <= '0;
         idx_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         amsb_q <= 1'b0;
         bmsb_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         c_q    <= c_d;
         sum_q  <= sum_d;
         idx_q  <= idx_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         amsb_q <= amsb_d;
         bmsb_q <= bmsb_d;
      end
   end

   // Output decode.
   always_comb begin
      busy     = (state_q == RUN);
      done     = (state_q == DONE);
      sum      = sum_q;
      cout     = cout_q;
      overflow = ovf_q;
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16), arithmetic reference model.
module tb_nibble_serial_add_ctrl;

   localparam int unsigned W   = 16;
   localparam int unsigned NIB = W / 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   int total;
   int bad;

   logic [W-1:0] prev_sum;
   logic         prev_cout;
   logic         prev_ovf;

   nibble_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
`ifdef NIBBLE_SERIAL_SUB_MODE_EN
      .sub      (sub),
`endif
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic, signed overflow from operand/result signs.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                        input logic msub, output logic [W-1:0] es, output logic ec,
                        output logic eo);
      int unsigned full;
      if (msub) begin
         full = int'(ma) + int'(16'hFFFF - mb) + 1;
         es   = full[W-1:0];
         ec   = full[W];
         eo   = (ma[W-1] != mb[W-1]) && (es[W-1] != ma[W-1]);
      end else begin
         full = int'(ma) + int'(mb) + int'(mcin);
         es   = full[W-1:0];
         ec   = full[W];
         eo   = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
      end
   endtask

   // One full operation from an idle/done state, with cycle-accurate checks.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic tsub);
      logic [W-1:0] es;
      logic         ec, eo;
      model(ta, tb_v, tcin, tsub, es, ec, eo);
      @(negedge clk);
      chk("pre_done_low", {16'd0, done}, 17'd0);
      chk("pre_sum_hold", {1'b0, sum}, {1'b0, prev_sum});
      start = 1'b1; a = ta; b = tb_v; cin = tcin; sub = tsub;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      chk("run_busy", {16'd0, busy}, 17'd1);
      chk("run_cout_hold", {16'd0, cout}, {16'd0, prev_cout});
      chk("run_ovf_hold", {16'd0, overflow}, {16'd0, prev_ovf});
      for (int i = 1; i < NIB; i++) begin
         @(negedge clk);
         chk("run_busy_n", {16'd0, busy}, 17'd1);
         chk("run_done_low", {16'd0, done}, 17'd0);
      end
      @(negedge clk);
      chk("done_pulse", {16'd0, done}, 17'd1);
      chk("done_busy_low", {16'd0, busy}, 17'd0);
      chk("sum", {1'b0, sum}, {1'b0, es});
      chk("cout", {16'd0, cout}, {16'd0, ec});
      chk("overflow", {16'd0, overflow}, {16'd0, eo});
      prev_sum = es; prev_cout = ec; prev_ovf = eo;
   endtask

   initial begin
      logic [W-1:0] es;
      logic         ec, eo;
      total = 0; bad = 0;
      prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #12;
      chk("rst_busy", {16'd0, busy}, 17'd0);
      chk("rst_done", {16'd0, done}, 17'd0);
      chk("rst_sum", {1'b0, sum}, 17'd0);
      chk("rst_cout", {16'd0, cout}, 17'd0);
      chk("rst_ovf", {16'd0, overflow}, 17'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
      chk("t1_sum", {1'b0, sum}, 17'h05555);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      chk("t2_sum", {1'b0, sum}, 17'h00000);
      chk("t2_cout", {16'd0, cout}, 17'd1);
      do_op(16'h000F, 16'h0000, 1'b1, 1'b0);
      chk("t2b_sum", {1'b0, sum}, 17'h00010);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      chk("t3_ovf", {16'd0, overflow}, 17'd1);
      do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
      chk("t3b_cout_ovf", {15'd0, cout, overflow}, 17'd3);

      // Start during RUN ignored, then back-to-back accept from DONE.
      @(negedge clk);
      chk("t4_idle", {16'd0, busy}, 17'd0);
      start = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555;
      chk("t4_busy", {16'd0, busy}, 17'd1);
      for (int i = 1; i < NIB; i++) begin
         @(negedge clk);
         chk("t4_busy_n", {16'd0, busy}, 17'd1);
      end
      @(negedge clk);
      chk("t4_done1", {16'd0, done}, 17'd1);
      chk("t4_sum1", {1'b0, sum}, 17'h00003);
      @(negedge clk);
      start = 1'b0;
      chk("t4_b2b_busy", {16'd0, busy}, 17'd1);
      chk("t4_b2b_done", {16'd0, done}, 17'd0);
      for (int i = 1; i < NIB; i++) @(negedge clk);
      @(negedge clk);
      chk("t4_done2", {16'd0, done}, 17'd1);
      chk("t4_sum2", {1'b0, sum}, 17'h0FFFF);
      chk("t4_flags2", {15'd0, cout, overflow}, 17'd0);
      prev_sum = 16'hFFFF; prev_cout = 1'b0; prev_ovf = 1'b0;

      // Asynchronous reset mid-RUN after 2nd compute edge.
      do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_busy_before", {16'd0, busy}, 17'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_busy", {16'd0, busy}, 17'd0);
      chk("t5_done", {16'd0, done}, 17'd0);
      chk("t5_sum", {1'b0, sum}, 17'd0);
      chk("t5_cout", {16'd0, cout}, 17'd0);
      chk("t5_ovf", {16'd0, overflow}, 17'd0);
      @(negedge clk);
      rst_n = 1'b1;
      prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t5_no_done", {15'd0, done, busy}, 17'd0);
      end
      do_op(16'h0100, 16'h0100, 1'b0, 1'b0);
      chk("t5_sum_after", {1'b0, sum}, 17'h00200);

`ifdef NIBBLE_SERIAL_SUB_MODE_EN
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1);
      chk("t6_sum", {1'b0, sum}, 17'h0FFFE);
      chk("t6_flags", {15'd0, cout, overflow}, 17'd0);
      do_op(16'h8000, 16'h0001, 1'b1, 1'b1);
      chk("t6b_sum", {1'b0, sum}, 17'h07FFF);
      chk("t6b_flags", {15'd0, cout, overflow}, 17'd3);
`endif

      // Randomized operations against the reference model.
      for (int i = 0; i < 24; i++) begin
         logic rs;
`ifdef NIBBLE_SERIAL_SUB_MODE_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         do_op(W'($urandom), W'($urandom), 1'($urandom), rs);
      end

      model(16'h0000, 16'h0000, 1'b0, 1'b0, es, ec, eo);
      do_op(16'h0000, 16'h0000, 1'b0, 1'b0);
      chk("zero_sum", {1'b0, sum}, {1'b0, es});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs a WIDTH-bit addition by driving one 4-bit ripple-carry adder slice over successive cycles, least-significant nibble first.
- Provides a start/busy/done handshake for the host.
- Registers the carry between nibbles and accumulates the result.
- Lets the design reuse a single 4-bit adder datapath for wide operands.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived localparam; number of compute cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled on the rising edge of clk
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry into nibble 0; captured when start is accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result becomes valid
- sum  output  WIDTH  result; held until the next accepted start
- cout  output  1  carry out of the MSB nibble
- overflow  output  1  signed (two's-complement) overflow flag

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, cout and overflow are 0; sum=0; operand, carry and nibble-index registers are 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture a, b and cin into registers, clear sum and the index, go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1):
  - Each edge feeds the low nibble of the A and B shift registers, plus the carry register, into the RCA slice.
  - The slice's 4-bit sum shifts into sum from the top (sum >> 4, new nibble at [WIDTH-1:WIDTH-4]).
  - The A and B registers shift right by 4.
  - The carry register takes the slice Cout.
  - The index increments.
  - On the edge where index == NIBBLES-1:
    - cout takes the slice Cout.
    - overflow = (a_msb == b_msb) && (new sum MSB != a_msb), using the MSBs captured at start.
    - State goes to DONE.
- DONE (busy=0, done=1 for exactly one cycle):
  - start=1 is accepted exactly as in IDLE (back-to-back operation, no idle bubble).
  - Otherwise go to IDLE.
- Latency: start accepted at edge E0. Compute edges are E1..E_NIBBLES. sum, cout and overflow are final and done=1 after edge E_NIBBLES. For WIDTH=16, done rises 4 edges after acceptance.
- start while in RUN: ignored; captured operands are unchanged.
- Output validity:
  - sum is partial and meaningless during RUN.
  - cout and overflow keep their previous values until the final compute edge.
- Operands: a, b and cin may change freely after acceptance.
- Reset mid-RUN: abort immediately to reset values; no done pulse is issued.
- WIDTH=4: a single compute cycle; behaviour is otherwise identical.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_MODE_EN.
- When defined:
  - Extra input port sub (1 bit), captured at start.
  - sub=1: B is stored as ~b and the initial carry is forced to 1 (cin is ignored), giving a - b.
  - cout=1 means no borrow.
  - overflow uses the inverted B MSB (standard subtract overflow).
- When undefined: the port is absent and the block performs addition only; behaviour is as above.

Decomposition:
- Shared package nibble_serial_pkg:
  - state enum typedef with encodings IDLE, RUN, DONE.
  - constant NIBBLE_W = 4.
- Sub-module nibble_rca4: combinational 4-bit ripple-carry slice.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout.
  - Built from four full-adder instances.
  - Instantiated once in the controller.

Test Plan (WIDTH=16):
1. a=0x1234, b=0x4321, cin=0, start for 1 cycle -> busy high for 4 cycles; done pulses once; sum=0x5555, cout=0, overflow=0.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0 (carry ripples across all 4 nibble cycles). Then a=0x000F, b=0x0000, cin=1 -> sum=0x0010, cout=0.
3. a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1. a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
4. Accept a=0x0001, b=0x0002; assert start with a=0xAAAA, b=0x5555 during RUN -> ignored, result sum=0x0003. Then hold start high in the DONE cycle with the new operands -> second op accepted with no idle cycle, sum=0xFFFF.
5. Drive rst_n low for 1 cycle after the 2nd compute edge -> all outputs 0 asynchronously and no done pulse; the next op a=0x0100, b=0x0100 gives sum=0x0200.
6. With NIBBLE_SERIAL_SUB_MODE_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, overflow=0. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1.
